// File: rtl/trace_writer.sv
// trace_writer: buffers (cmd, addr) records in a small FIFO and serializes each
// one as ASCII text: decimal cmd, one space, zero-padded lowercase hex address,
// then a line terminator. The output is a byte stream with a valid/ready handshake.
// Optional feature: define TRACE_CRLF_EN to end each record with CR LF instead of LF.
module trace_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_cmd,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  idle,
    output logic [15:0]           rec_count
);

    localparam int HEX_DIGITS = ADDR_WIDTH / 4;
    localparam int CNT_W      = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HEX_DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD_HI,
        CMD_LO,
        SPACE,
        HEX,
`ifdef TRACE_CRLF_EN
        CR,
`endif
        LF
    } state_t;

    typedef struct packed {
        logic [3:0]            cmd;
        logic [ADDR_WIDTH-1:0] addr;
    } rec_t;

    // ------------------------------------------------------------------
    // Record FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    rec_t           mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    rec_t           head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr[PTR_W-1:0]];

    // Write the incoming record into the slot addressed by the write pointer.
    // NOTE: the storage array has no reset; equal pointers mark every slot as
    // don't-care, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= rec_t'{cmd: in_cmd, addr: in_addr};
        end
    end

    // Advance the FIFO pointers on push and pop independently.
    // NOTE: sequential state uses <= so every flop samples pre-edge values
    // regardless of the order the statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    state_t           start_state;
    rec_t             rec_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hs;
    logic             load_cnt;
    logic             dec_cnt;
    logic             count_rec;
    logic [3:0]       cmd_digit;
    logic [3:0]       nib;
    logic [7:0]       hex_char;

    // A popped record starts with the tens digit only when it has one.
    assign start_state = (head.cmd >= 4'd10) ? CMD_HI : CMD_LO;
    assign hs          = out_valid && out_ready;
    assign idle        = empty && (state_q == IDLE);

    // Units digit of the command and ASCII of the currently addressed nibble.
    assign cmd_digit = (rec_q.cmd >= 4'd10) ? (rec_q.cmd - 4'd10) : rec_q.cmd;
    assign nib       = 4'(rec_q.addr >> {cnt_q, 2'b00});
    assign hex_char  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});

    // State, record register, nibble counter and completed-record counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rec_q     <= '0;
            cnt_q     <= '0;
            rec_count <= '0;
        end else begin
            state_q <= state_d;
            if (pop)       rec_q     <= head;
            if (load_cnt)  cnt_q     <= CNT_LAST;
            else if (dec_cnt) cnt_q  <= cnt_q - CNT_W'(1);
            if (count_rec) rec_count <= rec_count + 16'd1;
        end
    end

    // Next-state, output byte and side-effect strobes for the serializer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no branch can
        // leave it unassigned and infer a latch.
        state_d   = state_q;
        pop       = 1'b0;
        load_cnt  = 1'b0;
        dec_cnt   = 1'b0;
        count_rec = 1'b0;
        out_valid = (state_q != IDLE);
        out_byte  = 8'h00;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = start_state;
                end
            end
            CMD_HI: begin
                out_byte = 8'h31;
                if (hs) state_d = CMD_LO;
            end
            CMD_LO: begin
                out_byte = 8'h30 + {4'h0, cmd_digit};
                if (hs) state_d = SPACE;
            end
            SPACE: begin
                out_byte = 8'h20;
                if (hs) begin
                    load_cnt = 1'b1;
                    state_d  = HEX;
                end
            end
            HEX: begin
                out_byte = hex_char;
                if (hs) begin
                    dec_cnt = 1'b1;
                    if (cnt_q == '0) begin
`ifdef TRACE_CRLF_EN
                        state_d = CR;
`else
                        state_d = LF;
`endif
                    end
                end
            end
`ifdef TRACE_CRLF_EN
            CR: begin
                out_byte = 8'h0D;
                if (hs) state_d = LF;
            end
`endif
            LF: begin
                out_byte = 8'h0A;
                if (hs) begin
                    count_rec = 1'b1;
                    // Chain straight into the next record to avoid a bubble.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = start_state;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                out_valid = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trace_writer.sv
`timescale 1ns/1ps
// Directed bench for trace_writer. Expected byte streams are written out by hand
// as text; a negedge monitor captures every handshaked byte with its cycle stamp.
module tb_trace_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_cmd = '0;
    logic [31:0] in_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        idle;
    logic [15:0] rec_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int push_cyc = 0;

    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    trace_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .idle      (idle),
        .rec_count (rec_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture handshakes, check stall stability and zero byte when invalid.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_byte !== prev_byte) begin
                    miscompares++;
                    $display("FAIL stall_hold: out_valid=%b out_byte=%h, required 1 and %h",
                             out_valid, out_byte, prev_byte);
                end
            end
            if (out_valid !== 1'b1) begin
                vectors++;
                if (out_byte !== 8'h00) begin
                    miscompares++;
                    $display("FAIL invalid_byte: out_byte=%h while out_valid=0, required 00", out_byte);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got.push_back(out_byte);
                got_cyc.push_back(cyc);
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_byte  = out_byte;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_streams();
        got.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_streams();
    endtask

    // Append one record's expected text plus its line terminator.
    task automatic exp_add(input string text);
        for (int i = 0; i < text.len(); i++) exp_q.push_back(text[i]);
`ifdef TRACE_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    // Offer one record and hold it until accepted (bounded).
    task automatic push(input logic [3:0] c, input logic [31:0] a);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_cmd   = c;
        in_addr  = a;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            push_cyc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            miscompares++;
            $display("FAIL push_timeout: in_ready stayed 0 for cmd=%0d addr=%h", c, a);
        end
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 600 && got.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        vectors++;
        if (got.size() < n) begin
            miscompares++;
            $display("FAIL byte_timeout: got %0d bytes, required %0d", got.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out: out_valid=%b out_byte=%h, required 0 and 00", out_valid, out_byte);
        end
        do_reset();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: %b, required 1", in_ready);
        end
        vectors++;
        if (idle !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle: %b, required 1", idle);
        end
        vectors++;
        if (rec_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_rec_count: %0d, required 0", rec_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        exp_add("2 10019d94");
        push(4'd2, 32'h10019D94);
        wait_bytes(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL single_byte[%0d]: %h, required %h", i, got[i], exp_q[i]);
            end
        end
        vectors++;
        if (got_cyc[0] !== push_cyc + 2) begin
            miscompares++;
            $display("FAIL single_bubble: first byte at cycle %0d, required %0d", got_cyc[0], push_cyc + 2);
        end
        for (int i = 1; i < exp_q.size(); i++) begin
            vectors++;
            if (got_cyc[i] !== got_cyc[0] + i) begin
                miscompares++;
                $display("FAIL single_gap[%0d]: cycle %0d, required %0d", i, got_cyc[i], got_cyc[0] + i);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rec_count !== 16'd1 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done: rec_count=%0d idle=%b, required 1 and 1", rec_count, idle);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_add("12 ffffffff");
        exp_add("0 00000000");
        push(4'd12, 32'hFFFFFFFF);
        push(4'd0, 32'h00000000);
        wait_bytes(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_byte[%0d]: %h, required %h", i, got[i], exp_q[i]);
            end
        end
        for (int i = 1; i < exp_q.size(); i++) begin
            vectors++;
            if (got_cyc[i] !== got_cyc[0] + i) begin
                miscompares++;
                $display("FAIL b2b_gap[%0d]: cycle %0d, required %0d", i, got_cyc[i], got_cyc[0] + i);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rec_count !== 16'd2) begin
            miscompares++;
            $display("FAIL b2b_rec_count: %0d, required 2", rec_count);
        end
    endtask

    task automatic test_backpressure();
        bit stop = 1'b0;
        do_reset();
        exp_add("9 0a1b2c3f");
        fork
            begin
                for (int i = 0; i < 600 && !stop; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
            begin
                push(4'd9, 32'h0A1B2C3F);
                wait_bytes(exp_q.size());
                stop = 1'b1;
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_byte[%0d]: %h, required %h", i, got[i], exp_q[i]);
            end
        end
        for (int i = 1; i < exp_q.size(); i++) begin
            vectors++;
            if (got_cyc[i] !== got_cyc[0] + 2 * i) begin
                miscompares++;
                $display("FAIL bp_spacing[%0d]: cycle %0d, required %0d", i, got_cyc[i], got_cyc[0] + 2 * i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One record sits in the serializer and four in the FIFO; the sixth waits.
    task automatic test_fifo_full();
        bit seen = 1'b0;
        do_reset();
        out_ready = 1'b0;
        exp_add("1 00000001");
        exp_add("10 deadbeef");
        exp_add("15 12345678");
        exp_add("9 9abcdef0");
        exp_add("4 00ff00ff");
        exp_add("11 cafef00d");
        push(4'd1,  32'h00000001);
        push(4'd10, 32'hDEADBEEF);
        push(4'd15, 32'h12345678);
        push(4'd9,  32'h9ABCDEF0);
        push(4'd4,  32'h00FF00FF);
        in_valid = 1'b1;
        in_cmd   = 4'd11;
        in_addr  = 32'hCAFEF00D;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL full_in_ready: %b, required 0", in_ready);
            end
        end
        vectors++;
        if (got.size() !== 0 || rec_count !== 16'd0) begin
            miscompares++;
            $display("FAIL full_stalled: bytes=%0d rec_count=%0d, required 0 and 0", got.size(), rec_count);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = in_ready;
        end
        vectors++;
        if (!seen || rec_count !== 16'd1 || got.size() !== 12) begin
            miscompares++;
            $display("FAIL full_release: in_ready=%b rec_count=%0d bytes=%0d, required 1, 1, 12",
                     seen, rec_count, got.size());
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_bytes(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL full_byte[%0d]: %h, required %h", i, got[i], exp_q[i]);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rec_count !== 16'd6) begin
            miscompares++;
            $display("FAIL full_rec_count: %0d, required 6", rec_count);
        end
    endtask

    // Runs after test_fifo_full without a reset so rec_count is nonzero.
    task automatic test_reset_midrecord();
        out_ready = 1'b1;
        clear_streams();
        push(4'd2, 32'h10019D94);
        wait_bytes(5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || idle !== 1'b1 || rec_count !== 16'd0 ||
            in_ready !== 1'b1 || out_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset: out_valid=%b idle=%b rec_count=%0d in_ready=%b out_byte=%h, required 0,1,0,1,00",
                     out_valid, idle, rec_count, in_ready, out_byte);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_streams();
        exp_add("7 00c0ffee");
        push(4'd7, 32'h00C0FFEE);
        wait_bytes(exp_q.size());
        vectors++;
        if (got[0] !== 8'h37) begin
            miscompares++;
            $display("FAIL midreset_first: %h, required 37", got[0]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midreset_byte[%0d]: %h, required %h", i, got[i], exp_q[i]);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rec_count !== 16'd1) begin
            miscompares++;
            $display("FAIL midreset_rec_count: %0d, required 1", rec_count);
        end
    endtask

    // Terminator check: rec_count must move only on the final 0A handshake.
    task automatic test_crlf();
        do_reset();
        exp_add("3 0000abcd");
        push(4'd3, 32'h0000ABCD);
        wait_bytes(exp_q.size());
        vectors++;
        if (out_byte !== 8'h0A || rec_count !== 16'd0) begin
            miscompares++;
            $display("FAIL term_before_lf: out_byte=%h rec_count=%0d, required 0a and 0", out_byte, rec_count);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL term_byte[%0d]: %h, required %h", i, got[i], exp_q[i]);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rec_count !== 16'd1) begin
            miscompares++;
            $display("FAIL term_rec_count: %0d, required 1", rec_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fifo_full();
        test_reset_midrecord();
        test_crlf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
